// File: rtl/dbg_monitor.sv
// Parametrised pipeline-debug monitor: sticky valid/ready flags, saturating
// handshake counters, first-valid timestamps, address-match capture, registered readout.
module dbg_monitor #(
    parameter int          NUM_CH   = 8,
    parameter int          CNT_W    = 32,
    parameter int          NUM_CAP  = 2,
    parameter int          ADDR_W   = 16,
    parameter int          CAP_W    = 32,
    parameter logic [31:0] ID_VALUE = 32'd21392003,
    parameter int          SEL_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         vld_i,
    input  logic [NUM_CH-1:0]         rdy_i,
    input  logic                      clr_i,
    input  logic                      cap_en_i,
    input  logic [ADDR_W-1:0]         cap_addr_i,
    input  logic [CAP_W-1:0]          cap_data_i,
    input  logic                      cap_mode_i,
    input  logic [NUM_CAP*ADDR_W-1:0] match_addr_i,
    input  logic                      rd_en_i,
    input  logic [SEL_W-1:0]          rd_sel_i,
    output logic [31:0]               rd_data_o,
    output logic                      rd_vld_o,
    output logic [NUM_CH-1:0]         sticky_vld_o,
    output logic [NUM_CH-1:0]         sticky_rdy_o
);

    localparam int SEL_HS  = 4;
    localparam int SEL_TS  = SEL_HS + NUM_CH;
    localparam int SEL_CAP = SEL_TS + NUM_CH;
    localparam int SEL_HIT = SEL_CAP + NUM_CAP;

    logic [NUM_CH-1:0]  sticky_vld;
    logic [NUM_CH-1:0]  sticky_rdy;
    logic [CNT_W-1:0]   cyc;
    logic [CNT_W-1:0]   hs [NUM_CH];
    logic [CNT_W-1:0]   ts [NUM_CH];
    logic [CAP_W-1:0]   cap_data [NUM_CAP];
    logic [NUM_CAP-1:0] cap_hit;
    logic [NUM_CAP-1:0] cap_match;
    logic [31:0]        rd_mux;
    int                 sel_idx;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cap_match = '0;
        for (int k = 0; k < NUM_CAP; k++)
            cap_match[k] = cap_en_i && (cap_addr_i == match_addr_i[k*ADDR_W +: ADDR_W]);
    end

    // NOTE: the arrays are reset explicitly; they are debug registers, not RAM, and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_vld <= '0;
            sticky_rdy <= '0;
            cyc        <= '0;
            cap_hit    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hs[i] <= '0;
                ts[i] <= '0;
            end
            for (int k = 0; k < NUM_CAP; k++) cap_data[k] <= '0;
        end else if (clr_i) begin
            // clear wins over any event seen in the same cycle
            sticky_vld <= '0;
            sticky_rdy <= '0;
            cyc        <= '0;
            cap_hit    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hs[i] <= '0;
                ts[i] <= '0;
            end
            for (int k = 0; k < NUM_CAP; k++) cap_data[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every update based on pre-edge state.
            sticky_vld <= sticky_vld | vld_i;
            sticky_rdy <= sticky_rdy | rdy_i;
            cyc        <= cyc + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (vld_i[i] && rdy_i[i] && (hs[i] != '1)) hs[i] <= hs[i] + 1'b1;
                if (vld_i[i] && !sticky_vld[i])            ts[i] <= cyc;
            end
            for (int k = 0; k < NUM_CAP; k++) begin
                if (cap_match[k] && (cap_mode_i || !cap_hit[k])) begin
                    cap_data[k] <= cap_data_i;
                    cap_hit[k]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_mux  = '0;
        sel_idx = int'(rd_sel_i);
        if (sel_idx == 0) rd_mux = ID_VALUE;
        if (sel_idx == 1) rd_mux = 32'(sticky_vld);
        if (sel_idx == 2) rd_mux = 32'(sticky_rdy);
        if (sel_idx == 3) rd_mux = 32'(cyc);
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_idx == SEL_HS + i) rd_mux = 32'(hs[i]);
            if (sel_idx == SEL_TS + i) rd_mux = 32'(ts[i]);
        end
        for (int k = 0; k < NUM_CAP; k++)
            if (sel_idx == SEL_CAP + k) rd_mux = 32'(cap_data[k]);
        if (sel_idx == SEL_HIT) rd_mux = 32'(cap_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
            rd_vld_o  <= 1'b0;
        end else begin
            rd_vld_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_mux;
        end
    end

    assign sticky_vld_o = sticky_vld;
    assign sticky_rdy_o = sticky_rdy;

endmodule

// File: tb/tb_dbg_monitor.sv
// Directed bench for dbg_monitor: a default instance and a CNT_W=8 instance
// share stimulus; readout vectors are table-driven, corner cases hand-written.
module tb_dbg_monitor;

    localparam int          NUM_CH  = 8;
    localparam int          NUM_CAP = 2;
    localparam int          ADDR_W  = 16;
    localparam int          SEL_W   = 8;
    localparam logic [31:0] ID      = 32'd21392003;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_CH-1:0]         vld, rdy;
    logic                      clr, cap_en, cap_mode, rd_en;
    logic [ADDR_W-1:0]         cap_addr;
    logic [31:0]               cap_data;
    logic [NUM_CAP*ADDR_W-1:0] match_addr;
    logic [SEL_W-1:0]          rd_sel;

    logic [31:0]       rd_data, rd_data8;
    logic              rd_vld, rd_vld8;
    logic [NUM_CH-1:0] st_vld, st_rdy, st_vld8, st_rdy8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        logic [31:0] exp8;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    dbg_monitor dut (
        .clk(clk), .rst_n(rst_n), .vld_i(vld), .rdy_i(rdy), .clr_i(clr),
        .cap_en_i(cap_en), .cap_addr_i(cap_addr), .cap_data_i(cap_data),
        .cap_mode_i(cap_mode), .match_addr_i(match_addr), .rd_en_i(rd_en),
        .rd_sel_i(rd_sel), .rd_data_o(rd_data), .rd_vld_o(rd_vld),
        .sticky_vld_o(st_vld), .sticky_rdy_o(st_rdy)
    );

    dbg_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .vld_i(vld), .rdy_i(rdy), .clr_i(clr),
        .cap_en_i(cap_en), .cap_addr_i(cap_addr), .cap_data_i(cap_data),
        .cap_mode_i(cap_mode), .match_addr_i(match_addr), .rd_en_i(rd_en),
        .rd_sel_i(rd_sel), .rd_data_o(rd_data8), .rd_vld_o(rd_vld8),
        .sticky_vld_o(st_vld8), .sticky_rdy_o(st_rdy8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // all stimulus tasks start and end at a falling edge
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input string name, input int sel, input logic [31:0] exp, input logic [31:0] exp8);
        vec_t v;
        v.name = name; v.sel = sel; v.exp = exp; v.exp8 = exp8;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            rd_en  = 1'b1;
            rd_sel = SEL_W'(vecs[i].sel);
            step();
            check({vecs[i].name, " data"},  rd_data,  vecs[i].exp);
            check({vecs[i].name, " data8"}, rd_data8, vecs[i].exp8);
            check({vecs[i].name, " vld"},   32'({rd_vld8, rd_vld}), 32'd3);
        end
        rd_en = 1'b0;
        vecs.delete();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vld = '0; rdy = '0; clr = 1'b0; cap_en = 1'b0; cap_mode = 1'b0;
        cap_addr = '0; cap_data = '0; match_addr = '0; rd_en = 1'b0; rd_sel = '0;
        step(2);
        check("reset rd_vld", 32'(rd_vld), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset sticky", 32'({st_vld, st_rdy}), 32'd0);
        rst_n = 1'b1;

        // back-to-back reads right after reset; the 4th read sees three counter increments
        add("id", 0, ID, ID);
        add("sticky_vld", 1, 0, 0);
        add("sticky_rdy", 2, 0, 0);
        add("cyc", 3, 3, 3);
        add("hs0", 4, 0, 0);
        add("cap_hit", 22, 0, 0);
        add("sel255", 255, 0, 0);
        add("id again", 0, ID, ID);
        run_vecs();
        step();
        check("idle rd_vld", 32'(rd_vld), 32'd0);
        check("idle rd_data hold", rd_data, ID);

        // single-cycle valid pulse at cyc=10 inside a 5-cycle ready window
        do_clear();
        step(8);
        rdy[2] = 1'b1; step(2);
        vld[2] = 1'b1; step();
        vld[2] = 1'b0; step(2);
        rdy[2] = 1'b0;
        check("pulse sticky_vld_o", 32'(st_vld), 32'h04);
        check("pulse sticky_rdy_o", 32'(st_rdy), 32'h04);
        add("pulse sticky_vld", 1, 32'h04, 32'h04);
        add("pulse sticky_rdy", 2, 32'h04, 32'h04);
        add("pulse hs2", 6, 1, 1);
        add("pulse ts2", 14, 10, 10);
        add("pulse hs0", 4, 0, 0);
        run_vecs();
        step(5);
        check("pulse sticky_vld_o held", 32'(st_vld), 32'h04);

        // 300 handshakes: 8-bit instance saturates its counter and wraps its cycle count
        do_clear();
        vld[0] = 1'b1; rdy[0] = 1'b1;
        step(300);
        vld[0] = 1'b0; rdy[0] = 1'b0;
        add("sat cyc", 3, 300, 44);
        add("sat hs0", 4, 300, 255);
        add("sat ts0", 12, 0, 0);
        add("sat sticky_vld", 1, 32'h01, 32'h01);
        run_vecs();

        // capture mode 0: first match held
        do_clear();
        match_addr = {16'd20, 16'd10};
        cap_mode = 1'b0; cap_en = 1'b1; cap_addr = 16'd10;
        cap_data = 32'hAA; step();
        cap_data = 32'hBB; step();
        cap_en = 1'b0;
        add("m0 cap0", 20, 32'hAA, 32'hAA);
        add("m0 cap1", 21, 0, 0);
        add("m0 hit", 22, 32'h1, 32'h1);
        run_vecs();

        // capture mode 1: overwrite, both slots on the same address, qualifier and address honoured
        do_clear();
        match_addr = {16'd10, 16'd10};
        cap_mode = 1'b1; cap_en = 1'b1; cap_addr = 16'd10;
        cap_data = 32'hAA; step();
        cap_data = 32'hBB; step();
        cap_addr = 16'd11; cap_data = 32'hDD; step();
        cap_en = 1'b0; cap_addr = 16'd10; cap_data = 32'hCC; step();
        add("m1 cap0", 20, 32'hBB, 32'hBB);
        add("m1 cap1", 21, 32'hBB, 32'hBB);
        add("m1 hit", 22, 32'h3, 32'h3);
        run_vecs();

        // clear in the same cycle as a valid and a capture match
        vld[1] = 1'b1; cap_en = 1'b1; cap_addr = 16'd10; cap_data = 32'h55; clr = 1'b1;
        step();
        vld[1] = 1'b0; cap_en = 1'b0; clr = 1'b0;
        check("clr sticky_vld_o", 32'(st_vld), 32'd0);
        add("clr cyc", 3, 0, 0);
        add("clr id", 0, ID, ID);
        add("clr sticky_vld", 1, 0, 0);
        add("clr hs1", 5, 0, 0);
        add("clr ts1", 13, 0, 0);
        add("clr cap0", 20, 0, 0);
        add("clr hit", 22, 0, 0);
        run_vecs();

        // reset while reads are in flight
        vld[3] = 1'b1; step();
        vld[3] = 1'b0;
        rd_en = 1'b1; rd_sel = SEL_W'(1);
        @(posedge clk); #1;
        check("pre-reset rd_vld", 32'(rd_vld), 32'd1);
        check("pre-reset rd_data", rd_data, 32'h08);
        rst_n = 1'b0; #1;
        check("mid-read rst rd_vld", 32'(rd_vld), 32'd0);
        check("mid-read rst rd_data", rd_data, 32'd0);
        check("mid-read rst sticky", 32'(st_vld), 32'd0);
        step();
        rd_en = 1'b0;
        step();
        check("held rst rd_vld", 32'(rd_vld), 32'd0);
        rst_n = 1'b1;
        add("rst cyc", 3, 0, 0);
        add("rst sticky_vld", 1, 0, 0);
        add("rst hs3", 7, 0, 0);
        add("rst ts3", 15, 0, 0);
        add("rst cap0", 20, 0, 0);
        add("top sel 23", 23, 0, 0);
        add("top sel 255", 255, 0, 0);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dbg_monitor.md
Name: dbg_monitor

Overview:
- Parametrised pipeline-debug monitor that replaces the fixed 8-flag debugger.
- Observes NUM_CH valid/ready pairs, one per pipeline stage (SPMM, DMVM, softmax, aggregation, ...), and keeps the following per channel:
  - sticky valid and ready flags;
  - a saturating handshake counter;
  - a first-valid timestamp.
- Captures data words on configurable address matches.
- All state is read through a registered, address-selected readout port.
- Sits beside the GAT top level and drives the debug outputs.

Parameters:
NUM_CH, 8, number of monitored valid/ready channels (1..32)
CNT_W, 32, width of the handshake counters and of the cycle counter (8..64)
NUM_CAP, 2, number of address-match capture slots (1..8)
ADDR_W, 16, width of the capture address bus
CAP_W, 32, width of captured data (<= 32)
ID_VALUE, 21392003, constant returned at select 0
SEL_W, 8, width of the readout select

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
vld_i  in  NUM_CH  per-channel valid
rdy_i  in  NUM_CH  per-channel ready
clr_i  in  1  synchronous clear of all monitor state
cap_en_i  in  1  capture qualifier (e.g. BRAM write enable)
cap_addr_i  in  ADDR_W  address compared against match addresses
cap_data_i  in  CAP_W  data captured on match
cap_mode_i  in  1  0 = hold first match, 1 = overwrite on every match
match_addr_i  in  NUM_CAP*ADDR_W  match address per slot, slot k at bits [k*ADDR_W +: ADDR_W]
rd_en_i  in  1  readout request
rd_sel_i  in  SEL_W  readout select
rd_data_o  out  32  readout data
rd_vld_o  out  1  readout data valid
sticky_vld_o  out  NUM_CH  live sticky valid flags
sticky_rdy_o  out  NUM_CH  live sticky ready flags

Behaviour:
- Reset: all flags, counters, timestamps, capture slots and captured bits clear to 0; rd_data_o = 0; rd_vld_o = 0.
- Sticky flags: sticky_vld[i] sets in the cycle after vld_i[i] is first seen high and stays set until clr_i or reset. sticky_rdy behaves the same way. These outputs are registered.
- Cycle counter cyc: increments every cycle, wraps at 2^CNT_W.
- Handshake counter hs[i]: +1 in every cycle where vld_i[i] & rdy_i[i]; saturates at all-ones and never wraps.
- Timestamp ts[i]: latches cyc in the first cycle vld_i[i] is high while sticky_vld[i] == 0; held thereafter.
- Capture slot k: a match is cap_en_i & (cap_addr_i == match_addr[k]).
  - Mode 0: on a match with cap_hit[k] == 0, latch cap_data_i and set cap_hit[k]; later matches are ignored.
  - Mode 1: latch on every match and set cap_hit[k].
  - Several slots may match in the same cycle; each updates independently.
- clr_i: in the next cycle all state (including cyc) is 0. Events in the clear cycle are dropped; clear wins.
- Readout: rd_en_i in cycle T gives rd_vld_o = 1 and rd_data_o in cycle T+1.
  - Data reflects register state at T, before any update at T.
  - rd_vld_o = 0 when no request was made; rd_data_o holds its last value.
  - Reads are back-to-back capable, one per cycle.
- Select map (all values zero-extended to 32; CNT_W > 32 returns the low 32 bits):
  - 0: ID_VALUE
  - 1: sticky_vld
  - 2: sticky_rdy
  - 3: cyc
  - 4 .. 4+NUM_CH-1: hs[i]
  - next NUM_CH entries: ts[i]
  - next NUM_CAP entries: cap_data[k]
  - next entry: cap_hit vector
  - any higher select: 0
- No combinational path from any input to any output.
- Reset asserted mid-operation returns everything to reset values immediately, including a pending read; rd_vld_o = 0.

Test Plan:
- Reset then read sel 0, 1, 3 -> ID 21392003, 0x0, and cyc equal to the cycles elapsed since the counter started, with rd_vld_o one cycle after rd_en_i.
- Pulse vld_i[2] for 1 cycle at cyc = 10 and hold rdy_i[2] = 1 for 5 cycles spanning that pulse -> sticky_vld_o = 0x04 permanently, ts[2] = 10, hs[2] = 1.
- CNT_W = 8, hold vld_i[0] & rdy_i[0] for 300 cycles -> hs[0] = 255 (saturated); cyc wraps to 300 mod 256 relative to start.
- Mode 0, match_addr slot0 = 10, present address 10 with data 0xAA then 0xBB -> cap_data[0] = 0xAA, cap_hit = 0x1. Repeat in mode 1 -> 0xBB.
- clr_i asserted in the same cycle as vld_i[1] and a capture match -> all reads return 0 except sel 0, and sticky_vld_o = 0.
- Assert rst_n low mid-read (rd_en_i high) -> rd_vld_o = 0 and all state 0; read sel at the top of the range -> 0.
